// File: rtl/life_pkg.sv
// Shared selection/state types and pattern codes for the front-panel stage,
// the HEX display decoder and the initial-frame generator.
package life_pkg;

  typedef enum logic [1:0] {
    SHIP = 2'd0,
    BEE  = 2'd1,
    TOAD = 2'd2,
    RAND = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2
  } ctl_state_e;

  localparam logic [1:0] PAT_SHIP = 2'b00;
  localparam logic [1:0] PAT_BEE  = 2'b01;
  localparam logic [1:0] PAT_TOAD = 2'b10;

  function automatic sel_e sel_next(input sel_e s);
    sel_e n;
    case (s)
      SHIP:    n = BEE;
      BEE:     n = TOAD;
      TOAD:    n = RAND;
      default: n = SHIP;
    endcase
    return n;
  endfunction

  // RAND has no preset of its own; consumers see SHIP's code alongside random=1.
  function automatic logic [1:0] sel_pattern(input sel_e s);
    logic [1:0] p;
    case (s)
      BEE:     p = PAT_BEE;
      TOAD:    p = PAT_TOAD;
      default: p = PAT_SHIP;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizer plus counting debouncer for one active-low push button.
// Emits a one-cycle press pulse on each accepted release-to-press transition.
module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   w_sample;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_n};
    end
  end

  assign w_sample = r_sync[SYNC_STAGES-1];

  // A sample matching the accepted level restarts the count, so any bounce
  // forces a fresh run of stable samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (w_sample == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= w_sample;
        r_cnt   <= '0;
        r_press <= ~w_sample;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/mode_select.sv
// Front-panel control: button conditioning, start-pattern selection ring and
// the SELECT/LOAD/RUN sequencer that issues the initial-frame load pulse.
//
//   state  | meaning
//   SELECT | next cycles the ring, start commits the selection
//   LOAD   | one-cycle load pulse, button events dropped
//   RUN    | game running, selection frozen, start returns to SELECT
module mode_select
  import life_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_next_n,
  input  logic       key_start_n,
  output logic       random,
  output logic [1:0] pattern,
  output logic       load,
  output logic       running
);

  logic       w_next_ev;
  logic       w_start_ev;
  logic       w_next_level;
  logic       w_start_level;
  logic       w_unused;

  ctl_state_e r_state;
  ctl_state_e w_state_nxt;
  sel_e       r_sel;
  sel_e       w_sel_nxt;

  logic       r_random;
  logic [1:0] r_pattern;
  logic       r_load;
  logic       r_running;
  logic       w_random_nxt;
  logic [1:0] w_pattern_nxt;
  logic       w_load_nxt;
  logic       w_running_nxt;

  button_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next (
    .clk    (clk),
    .reset_n(reset_n),
    .i_key_n(key_next_n),
    .o_level(w_next_level),
    .o_press(w_next_ev)
  );

  button_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start (
    .clk    (clk),
    .reset_n(reset_n),
    .i_key_n(key_start_n),
    .o_level(w_start_level),
    .o_press(w_start_ev)
  );

  // Held levels are not needed here; only press events drive the sequencer.
  assign w_unused = &{1'b0, w_next_level, w_start_level};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SELECT;
      r_sel   <= SHIP;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Start takes priority over next so a simultaneous press commits the
  // current selection rather than the following one.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    case (r_state)
      SELECT: begin
        if (w_start_ev) begin
          w_state_nxt = LOAD;
        end else if (w_next_ev) begin
          w_sel_nxt = sel_next(r_sel);
        end
      end
      LOAD: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        if (w_start_ev) begin
          w_state_nxt = SELECT;
        end
      end
      default: begin
        w_state_nxt = SELECT;
      end
    endcase
  end

  always_comb begin
    w_random_nxt  = (w_sel_nxt == RAND);
    w_pattern_nxt = sel_pattern(w_sel_nxt);
    w_load_nxt    = (w_state_nxt == LOAD);
    w_running_nxt = (w_state_nxt == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_random  <= 1'b0;
      r_pattern <= PAT_SHIP;
      r_load    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_random  <= w_random_nxt;
      r_pattern <= w_pattern_nxt;
      r_load    <= w_load_nxt;
      r_running <= w_running_nxt;
    end
  end

  assign random  = r_random;
  assign pattern = r_pattern;
  assign load    = r_load;
  assign running = r_running;

endmodule

// File: tb/tb_mode_select.sv
// Scoreboard bench for mode_select: a cycle-level behavioural model queues
// expected output changes, a negedge monitor compares what the DUT shows.
module tb_mode_select;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int WIN  = SYNC + DEB + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_next_n = 1'b1;
  logic       key_start_n = 1'b1;
  logic       random;
  logic [1:0] pattern;
  logic       load;
  logic       running;

  mode_select #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_next_n (key_next_n),
    .key_start_n(key_start_n),
    .random     (random),
    .pattern    (pattern),
    .load       (load),
    .running    (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [4:0] outs;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: mode 0 = choosing, 1 = loading, 2 = running; sel counts the ring.
  int         m_mode;
  int         m_sel;
  logic       m_lvl[2];
  logic       m_ev[2];
  logic       hist[2][$];
  logic [4:0] m_prev = 5'b00000;

  function automatic logic [4:0] m_outs(input int mode, input int sel);
    logic [1:0] p;
    p = (sel == 3) ? 2'b00 : 2'(sel);
    return {(sel == 3), p, (mode == 1), (mode == 2)};
  endfunction

  task automatic m_reset();
    m_mode = 0;
    m_sel  = 0;
    for (int b = 0; b < 2; b++) begin
      m_lvl[b] = 1'b1;
      m_ev[b]  = 1'b0;
      hist[b].delete();
      for (int i = 0; i < WIN; i++) hist[b].push_back(1'b1);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    logic [4:0] o;
    logic       raw;
    logic       all_diff;
    if (!reset_n) begin
      m_reset();
      o = m_outs(m_mode, m_sel);
      if (o != m_prev) begin
        sbq.push_back('{tag: cyc, outs: o});
        m_prev = o;
      end
    end else begin
      if (m_mode == 1) m_mode = 2;
      else if (m_mode == 0) begin
        if (m_ev[1]) m_mode = 1;
        else if (m_ev[0]) m_sel = (m_sel + 1) % 4;
      end else if (m_ev[1]) m_mode = 0;
      // A level is accepted once DEB+1 consecutive samples, seen SYNC cycles
      // late, all disagree with the current level.
      for (int b = 0; b < 2; b++) begin
        raw = (b == 0) ? key_next_n : key_start_n;
        hist[b].push_back(raw);
        void'(hist[b].pop_front());
        all_diff = 1'b1;
        for (int i = 0; i <= DEB; i++) if (hist[b][i] == m_lvl[b]) all_diff = 1'b0;
        m_ev[b] = 1'b0;
        if (all_diff) begin
          m_lvl[b] = ~m_lvl[b];
          m_ev[b]  = (m_lvl[b] == 1'b0);
        end
      end
      o = m_outs(m_mode, m_sel);
      if (o != m_prev) begin
        sbq.push_back('{tag: cyc + 1, outs: o});
        m_prev = o;
      end
    end
  end

  logic       mon_en = 1'b0;
  logic [4:0] mon_last;
  logic [4:0] mon_exp;

  always @(negedge clk) begin
    logic [4:0] cur;
    bit         popped;
    if (mon_en) begin
      popped = 1'b0;
      cur = {random, pattern, load, running};
      while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
        mon_exp = sbq[0].outs;
        void'(sbq.pop_front());
        popped = 1'b1;
      end
      if (popped || cur !== mon_last) begin
        checks++;
        if (cur !== mon_exp) begin
          errors++;
          $display("FAIL outputs cyc=%0d random/pattern/load/running got %b_%b_%b_%b expected %b_%b_%b_%b",
                   cyc, cur[4], cur[3:2], cur[1], cur[0],
                   mon_exp[4], mon_exp[3:2], mon_exp[1], mon_exp[0]);
        end
      end
      mon_last = cur;
    end
  end

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic n, input logic s, input int k);
    key_next_n  = n;
    key_start_n = s;
    repeat (k) @(negedge clk);
  endtask

  task automatic press_next();
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 12);
  endtask

  task automatic press_start();
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 12);
  endtask

  initial begin
    int  waited;
    int  loads;
    int  kind;
    repeat (3) @(negedge clk);
    check("reset_random", {1'b0, random}, 2'b00);
    check("reset_pattern", pattern, 2'b00);
    check("reset_load", {1'b0, load}, 2'b00);
    check("reset_running", {1'b0, running}, 2'b00);
    reset_n  = 1'b1;
    mon_exp  = 5'b00000;
    mon_last = {random, pattern, load, running};
    mon_en   = 1'b1;
    repeat (100) @(negedge clk);

    // Ring walk, bounce, glitch
    repeat (4) press_next();
    drive(1'b0, 1'b1, 2);
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 12);
    drive(1'b0, 1'b1, 3);
    drive(1'b1, 1'b1, 12);
    check("after_bounce_glitch_pattern", pattern, 2'b01);

    // Start with TOAD, next ignored in RUN, stop
    press_next();
    press_start();
    check("run_running", {1'b0, running}, 2'b01);
    press_next();
    check("run_pattern_frozen", pattern, 2'b10);
    press_start();
    check("stopped_running", {1'b0, running}, 2'b00);

    // Simultaneous press with BEE selected
    repeat (3) press_next();
    drive(1'b0, 1'b0, 10);
    drive(1'b1, 1'b1, 12);
    check("both_pattern", pattern, 2'b01);
    check("both_running", {1'b0, running}, 2'b01);
    press_start();

    // Reset during the load cycle
    key_start_n = 1'b0;
    waited = 0;
    while (load !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (load !== 1'b1) begin
      errors++;
      $display("FAIL load_wait got load=%b expected 1 within 40 cycles", load);
    end
    #1 reset_n = 1'b0;
    #1;
    check("rst_load", {1'b0, load}, 2'b00);
    check("rst_running", {1'b0, running}, 2'b00);
    check("rst_pattern", pattern, 2'b00);
    key_start_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    loads = 0;
    repeat (30) begin
      @(negedge clk);
      if (load === 1'b1) loads++;
    end
    check("no_load_after_reset", 2'(loads), 2'b00);

    // Randomized presses, bounces and overlaps
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 5) drive(1'b0, 1'b1, $urandom_range(1, 12));
      else if (kind < 8) drive(1'b1, 1'b0, $urandom_range(1, 12));
      else drive(1'b0, 1'b0, $urandom_range(1, 12));
      drive(1'b1, 1'b1, $urandom_range(1, 14));
    end
    repeat (20) @(negedge clk);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_select.md
# mode_select

Front-panel control stage that sits directly upstream of the HEX-display decoder and the initial-frame generator. It synchronizes and debounces two active-low push buttons. It lets the user cycle through the preloaded starting patterns (SHIP, BEE, TOAD) and random seeding, and drives the `random` / `pattern` selection both consumers decode. On start, it issues a one-cycle `load` pulse to latch the initial frame, then holds the selection frozen while the game runs.

## Interface
- `SYNC_STAGES`, default 2: flops in each button synchronizer (minimum 2).
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required before a button level is accepted (minimum 1); counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_next_n`  in  1  raw button, active-low, asynchronous to `clk`; advances the selection.
- `key_start_n`  in  1  raw button, active-low, asynchronous; start/stop toggle.
- `random`  out  1  1 = random seeding selected.
- `pattern`  out  2  preset code: 00 SHIP, 01 BEE, 10 TOAD; forced to 00 when `random`=1.
- `load`  out  1  single-cycle pulse commanding the initial-frame load.
- `running`  out  1  1 while the game is running; selection locked.

## Operation
- Reset values: `random`=0, `pattern`=00 (SHIP), `load`=0, `running`=0, FSM=SELECT, debounced levels = released (1), debounce counters = 0, synchronizers = 1.
- Selection ring: SHIP → BEE → TOAD → RAND → SHIP. RAND drives `random`=1 and `pattern`=00. Code 11 is never driven.
- Debounce, per button:
  - Synchronized sample differs from the debounced level → counter increments.
  - Sample equals the debounced level → counter clears.
  - Counter reaches `DEBOUNCE_CYCLES` → debounced level flips and counter clears.
  - Press event = one-cycle pulse on a debounced 1→0 flip. A release generates no event.
- FSM states and transitions:
  - SELECT: a next event advances the ring. A start event goes to LOAD, and the selection does not change.
  - LOAD: `load`=1 for exactly this one cycle, then unconditionally to RUN. Next and start events arriving in this cycle are discarded.
  - RUN: `running`=1. Next events are ignored. A start event returns to SELECT, and `running` drops.
- Simultaneous next and start events in SELECT: start wins and the ring does not advance.
- Holding a button produces exactly one event; a second event requires release, debounce, and press again.
- Reset asserted mid-operation (any state, `load` high included) clears everything immediately. The selection returns to SHIP.

## Timing
- All outputs are registered; none combinationally depend on the inputs.
- Raw press to event: `SYNC_STAGES` + `DEBOUNCE_CYCLES` + 1 cycles of stable low. Any bounce restarts the count.
- Next event in cycle N: the new `random`/`pattern` value is visible in cycle N+1.
- Start event in cycle N (SELECT): `load`=1 in cycle N+1, `running`=1 from cycle N+2.
- Start event in cycle N (RUN): `running`=0 in cycle N+1.
- `random`/`pattern` are stable from the cycle before `load` through the whole RUN phase.

## Structure
- Shared package `life_pkg`:
  - `sel_e` enum: SHIP, BEE, TOAD, RAND.
  - `ctl_state_e` enum: SELECT, LOAD, RUN.
  - Pattern code constants `PAT_SHIP`=2'b00, `PAT_BEE`=2'b01, `PAT_TOAD`=2'b10. The display decoder and the initial-frame generator import the same constants.
- Sub-module `button_debounce`, parameterized by `SYNC_STAGES` and `DEBOUNCE_CYCLES`, with outputs debounced level and press pulse. It is instantiated twice.
- Top level holds the FSM, the selection register, and the output decode.

## Test plan
- Reset with `DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2: outputs are 0/00/0/0; released buttons produce no events for 100 cycles.
- Four clean next presses of 10 cycles each, in SELECT: `pattern`/`random` steps 01/0, 10/0, 00/1, 00/0, each update 8 cycles after the falling input edge.
- Next with bounce (low 2 cycles, high 1, low 10): exactly one advance, timed from the last falling edge; a 3-cycle glitch produces no advance.
- Start in SELECT with TOAD: `load` high exactly one cycle, `pattern`=10 throughout, `running`=1 the next cycle. Next presses in RUN leave `pattern`=10. A second start drops `running`.
- Both buttons falling in the same cycle in SELECT (BEE selected): LOAD is entered and `pattern` stays 01.
- `reset_n` pulsed low during the `load` cycle: `load` and `running` fall immediately, the selection returns to SHIP, and no `load` pulse follows reset release.
